// File: rtl/dram_cache_pkg.sv
// rtl/dram_cache_pkg.sv - shared response codes, FSM state enums and tag-word bit positions
package dram_cache_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'd0;
  localparam logic [1:0] BRESP_SLVERR = 2'd2;

  // Tag-word bit positions, counted down from the MSB of a TAG_S-wide word
  localparam int TAG_VALID_FROM_MSB = 1;
  localparam int TAG_DIRTY_FROM_MSB = 2;
  localparam int TAG_FIELD_FROM_MSB = 3;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/dram_cache_mem_array.sv
// rtl/dram_cache_mem_array.sv - tag/data storage with per-entry valid bits, one write port, one registered read port
module dram_cache_mem_array #(
  parameter int INDEX_W = 10,
  parameter int WIDTH   = 576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_re,
  input  logic [INDEX_W-1:0] i_raddr,
  output logic [WIDTH-1:0]   o_rdata
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Entries never written since reset read as zero; same-edge write is not visible to the read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_valid[i_waddr] <= 1'b1;
      end
      if (i_re) begin
        r_rdata <= r_valid[i_raddr] ? r_mem[i_raddr] : '0;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_cache_mem_model.sv
// rtl/dram_cache_mem_model.sv - AXI-style DRAM-cache tag/data memory model; DRAM_MEM_LAT_EN enables RD_LAT read latency
module dram_cache_mem_model
  import dram_cache_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int TAG_S    = 64,
  parameter int ID_W     = 16,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 6,
  parameter int RD_LAT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_W-1:0]         arid_i,
  input  logic [ADDR_W-1:0]       araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_W-1:0]         rid_o,
  output logic [TAG_S+DATA_W-1:0] rdata_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic [ID_W-1:0]         awid_i,
  input  logic [ADDR_W-1:0]       awaddr_i,
  input  logic                    awdirty_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_W-1:0]         wid_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_W-1:0]         bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i
);

  localparam int HI_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = TAG_S + DATA_W;

  generate
    if ((TAG_S - 2 < HI_W) || (RD_LAT < 1) || (RD_LAT > 255)) begin : g_bad_cfg
      $error("dram_cache_mem_model: tag word too narrow or RD_LAT outside 1..255");
    end
  endgenerate

  rd_state_t          r_rstate, w_rnext;
  wr_state_t          r_wstate, w_wnext;
  logic [ID_W-1:0]    r_arid, r_awid;
  logic [INDEX_W-1:0] r_rindex, r_windex;
  logic [TAG_S-1:0]   r_tag, w_tag;
  logic [1:0]         r_bresp;
  logic               w_ar_hs, w_aw_hs, w_re, w_we, w_id_match;
  logic [INDEX_W-1:0] w_ar_index, w_aw_index, w_raddr;
  logic               w_unused;

  assign w_ar_index = araddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_aw_index = awaddr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_ar_hs    = (r_rstate == R_IDLE) && arvalid_i;
  assign w_aw_hs    = (r_wstate == W_IDLE) && awvalid_i;
  assign w_id_match = (wid_i == r_awid);
  assign w_raddr    = (r_rstate == R_IDLE) ? w_ar_index : r_rindex;
  assign w_unused   = ^{araddr_i[ADDR_W-1:INDEX_W+OFFSET_W], araddr_i[OFFSET_W-1:0],
                        awaddr_i[OFFSET_W-1:0]};

  always_comb begin
    w_tag = '0;
    w_tag[TAG_S-TAG_VALID_FROM_MSB] = 1'b1;
    w_tag[TAG_S-TAG_DIRTY_FROM_MSB] = awdirty_i;
    w_tag[TAG_S-TAG_FIELD_FROM_MSB -: HI_W] = awaddr_i[ADDR_W-1 -: HI_W];
  end

`ifdef DRAM_MEM_LAT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_ar_hs) begin
      r_cnt <= 8'(RD_LAT - 1);
    end else if ((r_rstate == R_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_arid   <= '0;
      r_rindex <= '0;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) begin
        r_arid   <= arid_i;
        r_rindex <= w_ar_index;
      end
    end
  end

  // The array read is launched on the edge that enters R_RESP, so rdata_o holds through the response
  always_comb begin
    w_rnext = r_rstate;
    w_re    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (arvalid_i) begin
`ifdef DRAM_MEM_LAT_EN
          if (RD_LAT == 1) begin
            w_rnext = R_RESP;
            w_re    = 1'b1;
          end else begin
            w_rnext = R_WAIT;
          end
`else
          w_rnext = R_RESP;
          w_re    = 1'b1;
`endif
        end
      end
`ifdef DRAM_MEM_LAT_EN
      R_WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_rnext = R_RESP;
          w_re    = 1'b1;
        end
      end
`endif
      R_RESP: begin
        if (rready_i) begin
          w_rnext = R_IDLE;
        end
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_awid   <= '0;
      r_windex <= '0;
      r_tag    <= '0;
      r_bresp  <= BRESP_OKAY;
    end else begin
      r_wstate <= w_wnext;
      if (w_aw_hs) begin
        r_awid   <= awid_i;
        r_windex <= w_aw_index;
        r_tag    <= w_tag;
      end
      if ((r_wstate == W_DATA) && wvalid_i) begin
        r_bresp <= w_id_match ? BRESP_OKAY : BRESP_SLVERR;
      end
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    w_we    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (awvalid_i) begin
          w_wnext = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid_i) begin
          w_we    = w_id_match;
          w_wnext = W_RESP;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          w_wnext = W_IDLE;
        end
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  dram_cache_mem_array #(
    .INDEX_W (INDEX_W),
    .WIDTH   (LINE_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we && !rst),
    .i_waddr (r_windex),
    .i_wdata ({r_tag, wdata_i}),
    .i_re    (w_re && !rst),
    .i_raddr (w_raddr),
    .o_rdata (rdata_o)
  );

  assign arready_o = (r_rstate == R_IDLE);
  assign rvalid_o  = (r_rstate == R_RESP);
  assign rid_o     = r_arid;
  assign awready_o = (r_wstate == W_IDLE);
  assign wready_o  = (r_wstate == W_DATA);
  assign bvalid_o  = (r_wstate == W_RESP);
  assign bid_o     = r_awid;
  assign bresp_o   = r_bresp;

endmodule

// File: tb/tb_dram_cache_mem_model.sv
// tb/tb_dram_cache_mem_model.sv - directed and randomized checks of dram_cache_mem_model against a line-array model
module tb_dram_cache_mem_model;

  localparam int RD_LAT = 4;
`ifdef DRAM_MEM_LAT_EN
  localparam int EXP_LAT = RD_LAT;
`else
  localparam int EXP_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  arid_i, awid_i, wid_i;
  logic [63:0]  araddr_i, awaddr_i;
  logic         arvalid_i, awvalid_i, awdirty_i, wvalid_i, rready_i, bready_i;
  logic [511:0] wdata_i;
  logic         arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [15:0]  rid_o, bid_o;
  logic [575:0] rdata_o;
  logic [1:0]   bresp_o;

  int n_vec = 0;
  int n_err = 0;

  logic [575:0] model [1024];
  bit           mvalid [1024];

  dram_cache_mem_model #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awdirty_i(awdirty_i), .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_tag(input logic [63:0] addr, input logic dirty);
    return (64'h1 << 63) | (64'(dirty) << 62) | ((addr >> 16) << 14);
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic dirty, input logic [15:0] awid,
                          input logic [15:0] wid, input logic [511:0] data);
    int n;
    int idx;
    idx = int'((addr >> 6) % 1024);
    chk("awready_idle", awready_o, 1'b1);
    awid_i = awid; awaddr_i = addr; awdirty_i = dirty; awvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0;
    chk("awready_busy", awready_o, 1'b0);
    chk("wready", wready_o, 1'b1);
    wid_i = wid; wdata_i = data; wvalid_i = 1'b1;
    tick();
    wvalid_i = 1'b0;
    n = 0;
    while (!bvalid_o && n < 50) begin
      tick();
      n++;
    end
    chk("bvalid", bvalid_o, 1'b1);
    chk("bid", bid_o, awid);
    chk("bresp", bresp_o, (wid == awid) ? 2'd0 : 2'd2);
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    chk("bvalid_drop", bvalid_o, 1'b0);
    if (wid == awid) begin
      model[idx]  = {exp_tag(addr, dirty), data};
      mvalid[idx] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [15:0] id, input int hold,
                         input bit cw, input logic [63:0] cw_addr);
    logic [575:0] exp;
    int idx;
    int lat;
    idx = int'((addr >> 6) % 1024);
    exp = mvalid[idx] ? model[idx] : '0;
    chk("arready_idle", arready_o, 1'b1);
    arid_i = id; araddr_i = addr; arvalid_i = 1'b1;
    tick();
    arvalid_i = 1'b0;
    lat = 1;
    while (!rvalid_o && lat < 300) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, EXP_LAT);
    chk("rid", rid_o, id);
    chk("rdata", rdata_o, exp);
    if (cw) do_write(cw_addr, 1'b1, 16'h7, 16'h7, rand_data());
    for (int i = 0; i < hold; i++) begin
      chk("rvalid_hold", rvalid_o, 1'b1);
      chk("rdata_hold", rdata_o, exp);
      tick();
    end
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    chk("rvalid_drop", rvalid_o, 1'b0);
  endtask

  initial begin
    logic [63:0]  addr;
    logic [15:0]  id, wid;
    int           idx;
    for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    rst = 1'b1;
    arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awid_i = '0; awaddr_i = '0; awdirty_i = 1'b0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wvalid_i = 1'b0; bready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_arready", arready_o, 1'b1);
    chk("rst_awready", awready_o, 1'b1);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_wready", wready_o, 1'b0);
    chk("rst_bvalid", bvalid_o, 1'b0);
    chk("rst_rid", rid_o, 16'h0);
    chk("rst_bid", bid_o, 16'h0);
    chk("rst_bresp", bresp_o, 2'd0);
    chk("rst_rdata", rdata_o, 576'h0);

    do_read(64'h0000_0000_0000_FFC0, 16'h21, 0, 1'b0, '0);
    chk("unwritten_3ff", rdata_o, 576'h0);

    do_write(64'h0000_0000_0001_0040, 1'b0, 16'h5, 16'h5, {64{8'hA5}});
    do_read(64'h0000_0000_0001_0040, 16'h5, 0, 1'b0, '0);
    chk("known_tag", model[1][575:512], 64'h8000_0000_0000_4000);

    do_write(64'h0000_0000_0002_0080, 1'b1, 16'h3, 16'h4, rand_data());
    do_read(64'h0000_0000_0002_0080, 16'h9, 0, 1'b0, '0);

    do_write(64'h1234_5678_9ABC_00C0, 1'b1, 16'hBEEF, 16'hBEEF, rand_data());
    do_read(64'h1234_5678_9ABC_00C0, 16'h11, 4, 1'b1, 64'h0000_0000_0000_0100);
    do_read(64'h0000_0000_0000_0100, 16'h12, 0, 1'b0, '0);

    for (int k = 0; k < 40; k++) begin
      idx  = ($urandom % 9 == 0) ? 1023 : int'($urandom % 8);
      addr = {16'($urandom), 32'($urandom), 10'(idx), 6'($urandom)};
      id   = 16'($urandom);
      if ($urandom % 2 == 0) begin
        wid = ($urandom % 4 == 0) ? (id ^ 16'h1) : id;
        do_write(addr, 1'($urandom), id, wid, rand_data());
      end else begin
        do_read(addr, id, int'($urandom % 3), 1'b0, '0);
      end
    end

    do_write(64'h0000_0000_0000_0140, 1'b0, 16'h2, 16'h2, rand_data());
    awid_i = 16'h6; awaddr_i = 64'h0000_0000_0000_0140; awdirty_i = 1'b1; awvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0;
    chk("pre_rst_wready", wready_o, 1'b1);
    rst = 1'b1; wid_i = 16'h6; wdata_i = rand_data(); wvalid_i = 1'b1;
    tick();
    wvalid_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    chk("midrst_bvalid", bvalid_o, 1'b0);
    chk("midrst_wready", wready_o, 1'b0);
    tick();
    chk("midrst_bvalid_later", bvalid_o, 1'b0);
    do_read(64'h0000_0000_0000_0140, 16'h33, 0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
